wb_register_file: RTL

//  Architectural register file at the far end of the write-back path: sinks the

---
 rtl/wb_register_file_if.sv | 33 +++
 rtl/wb_register_file.sv | 72 +++++++
 2 files changed

// File: rtl/wb_register_file_if.sv
// Write-back / decode side bus of the architectural register file.
// slave = the register file, master = the pipeline stages driving it.
interface wb_register_file_if #(
  parameter int WORD   = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [WORD-1:0]   read_data1;
  logic [WORD-1:0]   read_data2;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [WORD-1:0]   write_back;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   pending_cnt;

  // Valid/ready does not apply here: reg_write and issue_valid are
  // single-cycle qualifiers, sampled on the rising clk edge when high.
  modport slave (
    input  read_reg1, read_reg2, reg_write, write_reg, write_back,
           issue_valid, issue_reg,
    output read_data1, read_data2, busy1, busy2, pending_cnt
  );

  modport master (
    output read_reg1, read_reg2, reg_write, write_reg, write_back,
           issue_valid, issue_reg,
    input  read_data1, read_data2, busy1, busy2, pending_cnt
  );
endinterface

// File: rtl/wb_register_file.sv
// Architectural register file X0..X30 plus hardwired-zero XZR, with
// write-first read bypass and an in-flight producer scoreboard.
module wb_register_file #(
  parameter int WORD   = 64,
  parameter int REGS   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_register_file_if.slave    bus
);
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(REGS - 1);
  localparam int CW = ADDR_W + 1;

  logic [WORD-1:0] regs_q [0:REGS-2];
  logic [REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic wr_en, set_req, set_eff, clr_eff;

  assign wr_en   = bus.reg_write && (bus.write_reg != XZR);
  assign set_req = bus.issue_valid && (bus.issue_reg != XZR);
  // A new issue to the same register outranks the retiring write-back.
  assign set_eff = set_req && !busy_q[bus.issue_reg];
  assign clr_eff = wr_en && busy_q[bus.write_reg] &&
                   !(set_req && (bus.issue_reg == bus.write_reg));

  always_comb begin
    busy_d = busy_q;
    if (wr_en)   busy_d[bus.write_reg] = 1'b0;
    if (set_req) busy_d[bus.issue_reg] = 1'b1;
    cnt_d = cnt_q;
    if (set_eff && !clr_eff)      cnt_d = cnt_q + CW'(1);
    else if (clr_eff && !set_eff) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS - 1; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[bus.write_reg] <= bus.write_back;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    bus.read_data1 = '0;
    if (bus.read_reg1 != XZR) begin
      if (bus.reg_write && (bus.write_reg == bus.read_reg1))
        bus.read_data1 = bus.write_back;
      else
        bus.read_data1 = regs_q[bus.read_reg1];
    end
    bus.read_data2 = '0;
    if (bus.read_reg2 != XZR) begin
      if (bus.reg_write && (bus.write_reg == bus.read_reg2))
        bus.read_data2 = bus.write_back;
      else
        bus.read_data2 = regs_q[bus.read_reg2];
    end
  end

  // A write-back completing this cycle already satisfies its consumers.
  assign bus.busy1 = busy_q[bus.read_reg1] &
                     ~(bus.reg_write & (bus.write_reg == bus.read_reg1));
  assign bus.busy2 = busy_q[bus.read_reg2] &
                     ~(bus.reg_write & (bus.write_reg == bus.read_reg2));
  assign bus.pending_cnt = cnt_q;
endmodule
